// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle, plus a read-only view of the FSM state.
// Handshake: a request transfers on a rising edge with in_valid && in_ready; a result
// transfers on a rising edge with out_valid && out_ready. Once raised, out_valid and the
// result stay stable until that transfer. out_valid and in_ready are never high together.
interface alu_multicycle_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_operandA;
  logic [WIDTH-1:0]   data_operandB;
  logic [4:0]         ctrl_ALUopcode;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_result;
  logic               isNotEqual;
  logic               isLessThan;
  logic               data_exception;
  logic [1:0]         dbg_state;

  modport master (
    output in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    input  in_ready, out_valid, data_result, isNotEqual, isLessThan, data_exception, dbg_state
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    output in_ready, out_valid, data_result, isNotEqual, isLessThan, data_exception, dbg_state
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle add/sub/and/or/sll/sra plus iterative signed mul/div,
// with results and flags returned through a valid/ready handshake.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  alu_multicycle_if.slave   bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  localparam logic [WIDTH-1:0]   MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               bzero_q, bzero_d;
  logic               dovf_q, dovf_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               ne_q, ne_d;
  logic               lt_q, lt_d;

  logic [WIDTH-1:0]   a, b;
  logic [4:0]         op;
  logic [SHAMT_W-1:0] sh;
  logic [WIDTH-1:0]   sum, diff, a_abs, b_abs;
  logic               add_ovf, sub_ovf;
  logic [WIDTH-1:0]   single_res;
  logic               single_exc;

  assign a  = bus.data_operandA;
  assign b  = bus.data_operandB;
  assign op = bus.ctrl_ALUopcode;
  assign sh = bus.ctrl_shiftamt;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  // Magnitude of MIN is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
  assign a_abs   = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_abs   = b[WIDTH-1] ? (~b + 1'b1) : b;

  always_comb begin
    single_res = '0;
    single_exc = 1'b0;
    case (op)
      OP_ADD: begin single_res = sum;  single_exc = add_ovf; end
      OP_SUB: begin single_res = diff; single_exc = sub_ovf; end
      OP_AND: single_res = a & b;
      OP_OR:  single_res = a | b;
      OP_SLL: single_res = a << sh;
      OP_SRA: single_res = $signed(a) >>> sh;
      default: ;
    endcase
  end

  // One radix-2 step. Multiply: {hi,lo} holds partial product with the multiplier
  // shifting out of lo. Divide: hi is the remainder, lo shifts dividend out / quotient in.
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0]   it_hi, it_lo;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic               mul_ovf;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mcand_q};
    if (is_div_q) begin
      it_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod    = {it_hi, it_lo};
    prod_s  = neg_q ? -prod : prod;
    quo_s   = neg_q ? -it_lo : it_lo;
    mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    bzero_d  = bzero_q;
    dovf_d   = dovf_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    exc_d    = exc_q;
    ne_d     = ne_q;
    lt_d     = lt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          ne_d = (a != b);
          lt_d = diff[WIDTH-1] ^ sub_ovf;
          if (op == OP_MUL || op == OP_DIV) begin
            state_d  = S_BUSY;
            cnt_d    = '0;
            is_div_d = (op == OP_DIV);
            neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
            bzero_d  = (b == '0);
            dovf_d   = (a == MIN_VAL) && (b == '1);
            mcand_d  = (op == OP_DIV) ? b_abs : a_abs;
            hi_d     = '0;
            lo_d     = (op == OP_DIV) ? a_abs : b_abs;
          end else begin
            state_d  = S_DONE;
            result_d = single_res;
            exc_d    = single_exc;
          end
        end
      end
      S_BUSY: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (is_div_q) begin
            result_d = bzero_q ? '0 : quo_s;
            exc_d    = bzero_q | dovf_q;
          end else begin
            result_d = prod_s[WIDTH-1:0];
            exc_d    = mul_ovf;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      dovf_q   <= 1'b0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      dovf_q   <= dovf_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
    end
  end

  assign bus.in_ready       = (state_q == S_IDLE);
  assign bus.out_valid      = (state_q == S_DONE);
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.isNotEqual     = ne_q;
  assign bus.isLessThan     = lt_q;
  assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: arithmetic reference model, expected-result queue,
// latency/backpressure/reset checks and literal test-plan vectors.
module tb_alu_multicycle;
  localparam int W = 32;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4, OP_SRA = 5'd5, OP_MUL = 5'd6, OP_DIV = 5'd7;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alu_multicycle_if #(.WIDTH(W)) bus();
  alu_multicycle #(.WIDTH(W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [W+2:0] exp_q[$];   // {isLessThan, isNotEqual, exception, result}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: plain signed integer arithmetic on 32/64-bit values.
  function automatic logic [W+2:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] sh);
    int sa, sb, rt;
    longint la, lb, r64, back;
    logic [W-1:0] res;
    logic exc;
    sa = a; sb = b; la = sa; lb = sb;
    res = '0; exc = 1'b0; r64 = 0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL: begin
        if (op == OP_ADD) r64 = la + lb;
        else if (op == OP_SUB) r64 = la - lb;
        else r64 = la * lb;
        res = r64[31:0];
        rt = res; back = rt;
        exc = (back != r64);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_SLL: res = a << sh;
      OP_SRA: begin r64 = la >>> sh; res = r64[31:0]; end
      OP_DIV: begin
        if (b == 0) begin res = '0; exc = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin res = a; exc = 1'b1; end
        else begin rt = sa / sb; res = rt; end
      end
      default: ;
    endcase
    return {(sa < sb), (a != b), exc, res};
  endfunction

  // Compare process: every cycle the result is presented it must match the queue head.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("valid_ready_exclusive", {63'd0, bus.out_valid && bus.in_ready}, 64'd0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          chk("dut_vs_model", {29'd0, bus.isLessThan, bus.isNotEqual, bus.data_exception,
                               bus.data_result}, {29'd0, exp_q[0]});
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh, input int stall,
                       output logic [W+2:0] got, output int lat);
    int n;
    n = 0; got = '0; lat = 0;
    while (!bus.in_ready && n < 100) begin @(posedge clock); #1; n++; end
    if (!bus.in_ready) begin chk("in_ready_timeout", 64'd0, 64'd1); return; end
    bus.in_valid = 1'b1;
    bus.data_operandA = a; bus.data_operandB = b;
    bus.ctrl_ALUopcode = op; bus.ctrl_shiftamt = sh;
    bus.out_ready = (stall == 0);
    @(posedge clock);
    exp_q.push_back(model(op, a, b, sh));
    #1;
    bus.in_valid = 1'b0;
    bus.data_operandA = $urandom; bus.data_operandB = $urandom;
    bus.ctrl_ALUopcode = 5'($urandom_range(0, 7)); bus.ctrl_shiftamt = 5'($urandom_range(0, 31));
    while (lat < 100) begin
      @(negedge clock);
      lat++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) begin chk("out_valid_timeout", 64'd0, 64'd1); return; end
    got = {bus.isLessThan, bus.isNotEqual, bus.data_exception, bus.data_result};
    chk("latency", 64'(lat), (op == OP_MUL || op == OP_DIV) ? 64'(W + 1) : 64'd1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      bus.in_valid = i[0];
      @(negedge clock);
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
    end
    if (stall > 0) begin
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    chk("idle_after_handshake", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  logic [W+2:0] got;
  int lat;
  logic [4:0] rop;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.data_operandA = '0; bus.data_operandB = '0;
    bus.ctrl_ALUopcode = '0; bus.ctrl_shiftamt = '0;

    // Model pinned against hand-computed values.
    chk("model_add_ovf", {29'd0, model(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0)}, {29'd0, 3'b011, 32'h8000_0000});
    chk("model_mul", {29'd0, model(OP_MUL, 32'hFFFF_FFF9, 32'd6, 5'd0)}, {29'd0, 3'b110, 32'hFFFF_FFD6});
    chk("model_div", {29'd0, model(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd0)}, {29'd0, 3'b010, 32'hFFFF_FFFD});

    repeat (2) @(posedge clock);
    #1;
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_result", {32'd0, bus.data_result}, 64'd0);
    chk("reset_flags", {61'd0, bus.isNotEqual, bus.isLessThan, bus.data_exception}, 64'd0);
    chk("reset_state", {62'd0, bus.dbg_state}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("in_ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

    do_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, got, lat);
    chk("tp_add_ovf", {29'd0, got}, {29'd0, 3'b011, 32'h8000_0000});
    chk("tp_add_latency", 64'(lat), 64'd1);
    do_op(OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 0, got, lat);
    chk("tp_sub_ovf", {29'd0, got}, {29'd0, 3'b111, 32'h7FFF_FFFF});
    do_op(OP_SRA, 32'hF000_0000, 32'd0, 5'd4, 0, got, lat);
    chk("tp_sra4", {29'd0, got}, {29'd0, 3'b110, 32'hFF00_0000});
    do_op(OP_SLL, 32'hF000_0000, 32'd0, 5'd4, 0, got, lat);
    chk("tp_sll4", {29'd0, got}, {29'd0, 3'b110, 32'h0000_0000});
    do_op(OP_SRA, 32'hF000_0000, 32'd0, 5'd0, 0, got, lat);
    chk("tp_sra0", {29'd0, got}, {29'd0, 3'b110, 32'hF000_0000});
    do_op(OP_MUL, 32'hFFFF_FFF9, 32'd6, 5'd0, 0, got, lat);
    chk("tp_mul", {29'd0, got}, {29'd0, 3'b110, 32'hFFFF_FFD6});
    chk("tp_mul_latency", 64'(lat), 64'd33);
    do_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd0, 0, got, lat);
    chk("tp_mul_ovf", {29'd0, got}, {29'd0, 3'b001, 32'h0});
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd0, 0, got, lat);
    chk("tp_div_neg", {29'd0, got}, {29'd0, 3'b010, 32'hFFFF_FFFD});
    do_op(OP_DIV, 32'd5, 32'd0, 5'd0, 0, got, lat);
    chk("tp_div_zero", {29'd0, got}, {29'd0, 3'b011, 32'h0});
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, got, lat);
    chk("tp_div_min", {29'd0, got}, {29'd0, 3'b111, 32'h8000_0000});

    // Backpressure with ignored in_valid pulses.
    do_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 5, got, lat);
    chk("tp_and_stall", {29'd0, got}, {29'd0, 3'b110, 32'h00F0_1234});
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd0, 3, got, lat);

    // Model-only vectors: equal operands, invalid opcode, edge multiplies/divides.
    do_op(OP_OR, 32'h1234_5678, 32'h1234_5678, 5'd0, 0, got, lat);
    do_op(5'b11111, 32'h1, 32'h2, 5'd3, 0, got, lat);
    do_op(5'b01000, 32'hFFFF_FFFF, 32'h5, 5'd1, 0, got, lat);
    do_op(OP_MUL, 32'h8000_0000, 32'd1, 5'd0, 0, got, lat);
    do_op(OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, got, lat);
    do_op(OP_MUL, 32'hFFFF_8000, 32'h0001_0000, 5'd0, 0, got, lat);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd0, 0, got, lat);
    do_op(OP_SUB, 32'd3, 32'd3, 5'd0, 0, got, lat);
    do_op(OP_SRA, 32'h7000_0000, 32'd1, 5'd31, 0, got, lat);
    for (int i = 0; i < 12; i++) begin
      rop = 5'($urandom_range(0, 9));
      do_op(rop, $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
            5'($urandom_range(0, 31)), int'($urandom_range(0, 2)), got, lat);
    end

    // Reset mid-multiply aborts with no output.
    bus.in_valid = 1'b1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd9;
    bus.ctrl_ALUopcode = OP_MUL; bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("abort_state_idle", {62'd0, bus.dbg_state}, 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      chk("abort_no_output", {63'd0, bus.out_valid}, 64'd0);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    do_op(OP_MUL, 32'hFFFF_FFF9, 32'd6, 5'd0, 0, got, lat);
    chk("post_reset_mul", {29'd0, got}, {29'd0, 3'b110, 32'hFFFF_FFD6});

    repeat (3) @(posedge clock);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
